// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
// Three-stage pipelined unsigned multiplier with a per-transaction choice
// between the exact product and a truncated/compensated approximation.
// Both products are formed side by side in the reduction stage. The output
// stage selects one of them and reports the signed error against the exact
// result. A saturating counter tracks delivered approximate results.
// The whole pipe freezes while the sink withholds out_ready.

module approx_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 8,
    parameter int COMP  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [2*WIDTH:0]     out_err,
    output logic                 out_mode,
    output logic [15:0]          approx_cnt
);

    localparam int PW = 2 * WIDTH;

    // The low result bits carry the compensation constant, clipped to the
    // truncated columns. With TRUNC = 0 this mask is empty, so both modes agree.
    localparam logic [PW-1:0] LOW_MASK = (PW'(1) << TRUNC) - PW'(1);
    localparam logic [PW-1:0] COMP_LOW = PW'(COMP) & LOW_MASK;

    // Approximate product: keep every partial product in columns >= TRUNC.
    // Fold the OR of column TRUNC-1 in as a single rounding bit at weight
    // 2^TRUNC, then place the compensation constant below.
    function automatic logic [PW-1:0] approx_product(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [PW-1:0] high_sum;
        logic [PW-1:0] term;
        logic          round_bit;
        high_sum  = '0;
        round_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                term        = '0;
                term[i + j] = a[i] & b[j];
                if (i + j >= TRUNC) begin
                    high_sum = high_sum + term;
                end else if (i + j == TRUNC - 1) begin
                    round_bit = round_bit | (a[i] & b[j]);
                end else begin
                    round_bit = round_bit;
                end
            end
        end
        return (((high_sum >> TRUNC) + PW'(round_bit)) << TRUNC) | COMP_LOW;
    endfunction

    logic              stall_s;
    logic              advance_s;

    logic              s1_valid_r;
    logic [WIDTH-1:0]  s1_a_r;
    logic [WIDTH-1:0]  s1_b_r;
    logic              s1_mode_r;

    logic              s2_valid_r;
    logic [PW-1:0]     s2_exact_r;
    logic [PW-1:0]     s2_approx_r;
    logic              s2_mode_r;

    logic [PW-1:0]     exact_s;
    logic [PW-1:0]     approx_s;
    logic [PW-1:0]     sel_p_s;
    logic [PW:0]       err_s;

    // Stall when a result is waiting on a sink that is not ready. in_ready follows immediately.
    always_comb begin
        stall_s   = out_valid & ~out_ready;
        advance_s = ~stall_s;
        in_ready  = advance_s;
    end

    // Reduction-stage arithmetic: exact and approximate products from S1.
    always_comb begin
        exact_s  = PW'(s1_a_r) * PW'(s1_b_r);
        approx_s = approx_product(s1_a_r, s1_b_r);
    end

    // Output-stage selection and signed error, computed one bit wider than the product.
    always_comb begin
        if (s2_mode_r) begin
            sel_p_s = s2_approx_r;
        end else begin
            sel_p_s = s2_exact_r;
        end
        err_s = {1'b0, s2_exact_r} - {1'b0, sel_p_s};
    end

    // S1: capture operands and mode when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_mode_r  <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r    <= in_a;
                s1_b_r    <= in_b;
                s1_mode_r <= in_mode;
            end
        end
    end

    // S2: register both candidate products alongside the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_exact_r  <= '0;
            s2_approx_r <= '0;
            s2_mode_r   <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_exact_r  <= exact_s;
                s2_approx_r <= approx_s;
                s2_mode_r   <= s1_mode_r;
            end
        end
    end

    // S3: output register. It refills on the same edge the previous result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_err   <= '0;
            out_mode  <= 1'b0;
        end else if (advance_s) begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                out_p    <= sel_p_s;
                out_err  <= err_s;
                out_mode <= s2_mode_r;
            end
        end
    end

    // Count delivered approximate results, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= 16'h0000;
        end else if (out_valid && out_ready && out_mode && (approx_cnt != 16'hFFFF)) begin
            approx_cnt <= approx_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe (WIDTH=8, TRUNC=8, COMP=6).
// A column-counting model predicts each result as operands are accepted.
// A single negedge process checks every delivered result and the counter.
// Directed tests pin literal values.

module tb_approx_mult_pipe;

    localparam int W  = 8;
    localparam int TR = 8;
    localparam int CP = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic [2*W:0]  out_err;
    logic          out_mode;
    logic [15:0]   approx_cnt;

    approx_mult_pipe #(.WIDTH(W), .TRUNC(TR), .COMP(CP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_err(out_err), .out_mode(out_mode),
        .approx_cnt(approx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int err;
        bit mode;
    } exp_t;

    exp_t exp_q[$];
    int   log_p[$];
    int   log_err[$];
    int   log_cyc[$];
    int   model_cnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Reference rule: count the ones in each product column c >= TRUNC.
    // Add one unit if column TRUNC-1 has any set bit, then append COMP below.
    function automatic int model_p(input int a, input int b, input bit mode);
        int h;
        int e;
        int n;
        h = 0;
        e = 0;
        if (!mode) return a * b;
        for (int c = 0; c <= 2 * W - 2; c++) begin
            n = 0;
            for (int i = 0; i < W; i++) begin
                if ((c - i) >= 0 && (c - i) < W && ((a >> i) & 1) == 1 && ((b >> (c - i)) & 1) == 1)
                    n++;
            end
            if (c >= TR) h = h + (n << c);
            if (c == TR - 1 && n > 0) e = 1;
        end
        return ((h >> TR) + e) * (1 << TR) + (CP % (1 << TR));
    endfunction

    // Scoreboard: predict on input transfer, check on output transfer, track the counter.
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            chk("approx_cnt", approx_cnt, model_cnt);
            if (in_valid && in_ready) begin
                x.p    = model_p(int'(in_a), int'(in_b), in_mode);
                x.err  = int'(in_a) * int'(in_b) - x.p;
                x.mode = in_mode;
                exp_q.push_back(x);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("out_p", out_p, x.p);
                    chk("out_err", int'($signed(out_err)), x.err);
                    chk("out_mode", out_mode, x.mode);
                    log_p.push_back(int'(out_p));
                    log_err.push_back(int'($signed(out_err)));
                    log_cyc.push_back(cyc);
                    if (x.mode && model_cnt != 65535) model_cnt = model_cnt + 1;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int g;
        logic acc;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        g = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_approx_cnt", approx_cnt, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_3x5", model_p(3, 5, 1'b1), 6);
        chk("model_128x1", model_p(128, 1, 1'b1), 262);
        chk("model_255x255", model_p(255, 255, 1'b1), 63494);
        chk("model_exact", model_p(255, 255, 1'b0), 65025);

        // Exact mode and two-edge latency.
        send(8'd255, 8'd255, 1'b0);
        @(negedge clk); chk("lat_n", out_valid, 0);
        @(negedge clk); chk("lat_n1", out_valid, 0);
        @(negedge clk); chk("lat_n2", out_valid, 1);
        chk("exact_p", out_p, 65025);
        chk("exact_err", out_err, 0);
        drain();

        // Approximate directed vectors, checked in order against literals.
        send(8'd3, 8'd5, 1'b1);
        send(8'd128, 8'd1, 1'b1);
        send(8'd255, 8'd255, 1'b1);
        drain();
        n0 = log_p.size();
        chk("ap0_p", log_p[n0-3], 6);
        chk("ap0_err", log_err[n0-3], 9);
        chk("ap1_p", log_p[n0-2], 262);
        chk("ap1_err", log_err[n0-2], -134);
        chk("ap2_p", log_p[n0-1], 63494);
        chk("ap2_err", log_err[n0-1], 1531);

        // Back-to-back random stream.
        n0 = log_p.size();
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            logic m;
            m = 1'($urandom_range(0, 1));
            if (m) n1++;
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), m);
        end
        drain();
        chk("stream_count", log_p.size() - n0, 10);
        chk("stream_consecutive", log_cyc[n0+9] - log_cyc[n0], 9);
        chk("stream_cnt", approx_cnt, 3 + n1);

        // Backpressure with a full pipe.
        n0 = log_p.size();
        out_ready = 1'b0;
        send(8'd200, 8'd100, 1'b1);
        send(8'd17, 8'd33, 1'b0);
        send(8'd99, 8'd250, 1'b1);
        in_a = 8'd7; in_b = 8'd9; in_mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_p_stable", out_p, model_p(200, 100, 1'b1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'd7, 8'd9, 1'b1);
        drain();
        chk("bp_delivered", log_p.size() - n0, 4);

        // Reset with three transactions in flight.
        send(8'd11, 8'd12, 1'b1);
        send(8'd13, 8'd14, 1'b1);
        send(8'd15, 8'd16, 1'b0);
        n0 = log_p.size();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cnt", approx_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", out_valid, 0);
        end
        chk("postrst_no_delivery", log_p.size() - n0, 0);

        // Counter saturation.
        for (int i = 0; i < 65540; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        end
        drain();
        chk("sat_cnt", approx_cnt, 16'hFFFF);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
